// File: rtl/sint_chunked_add_pkg.sv
// Shared types and constants for the chunked signed adder sequencer.
// The saturation constants serve builds with SINT_CHUNKED_ADD_SATURATE_EN defined.
package sint_chunked_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CHUNK_W_DEF = 7;
  localparam int NCHUNKS_DEF = 4;
  localparam int W_DEF       = CHUNK_W_DEF * NCHUNKS_DEF;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W_DEF = idx_width(NCHUNKS_DEF);

  localparam logic [W_DEF-1:0] SAT_POS_DEF = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic [W_DEF-1:0] SAT_NEG_DEF = {1'b1, {(W_DEF-1){1'b0}}};

endpackage

// File: rtl/sint_chunk_adc.sv
// Narrow CHUNK_W-bit add-with-carry stage, time-shared by the sequencer.
module sint_chunk_adc
  import sint_chunked_add_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               cin_i,
  output logic [CHUNK_W-1:0] sum_o,
  output logic               cout_o
);

  logic [CHUNK_W:0] total;

  always_comb begin
    total  = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK_W{1'b0}}, cin_i};
    sum_o  = total[CHUNK_W-1:0];
    cout_o = total[CHUNK_W];
  end

endmodule

// File: rtl/sint_chunked_add_seq.sv
// Multi-precision signed adder: one CHUNK_W slice per cycle, LSB slice first.
// Optional macro SINT_CHUNKED_ADD_SATURATE_EN clamps SUM to the signed limit on overflow.
module sint_chunked_add_seq
  import sint_chunked_add_pkg::*;
#(
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int NCHUNKS = NCHUNKS_DEF
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHUNK_W*NCHUNKS-1:0] A,
  input  logic [CHUNK_W*NCHUNKS-1:0] B,
  input  logic                       CIN,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHUNK_W*NCHUNKS-1:0] SUM,
  output logic                       COUT,
  output logic                       OVF
);

  localparam int W     = CHUNK_W * NCHUNKS;
  localparam int IDX_W = idx_width(NCHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNKS - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic [W-1:0]       sum_d;
  logic               cout_q;
  logic               ovf_q;

  logic [CHUNK_W-1:0] slice_sum;
  logic               slice_cout;
  logic               last_slice;
  logic               ovf_term;

  sint_chunk_adc #(.CHUNK_W(CHUNK_W)) u_adc (
    .a_i    (a_q[CHUNK_W-1:0]),
    .b_i    (b_q[CHUNK_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  assign last_slice = (idx_q == LAST_IDX);
  // Only meaningful on the last slice, where the slice MSBs are the operand sign bits.
  assign ovf_term   = (a_q[CHUNK_W-1] == b_q[CHUNK_W-1]) &&
                      (slice_sum[CHUNK_W-1] != a_q[CHUNK_W-1]);

  always_comb begin
    sum_d = {slice_sum, sum_q[W-1:CHUNK_W]};
`ifdef SINT_CHUNKED_ADD_SATURATE_EN
    if (last_slice && ovf_term) begin
      sum_d = a_q[CHUNK_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= CIN;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK_W;
          b_q     <= b_q >> CHUNK_W;
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          if (last_slice) begin
            cout_q  <= slice_cout;
            ovf_q   <= ovf_term;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign SUM       = sum_q;
  assign COUT      = cout_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_sint_chunked_add_seq.sv
// Self-checking bench for sint_chunked_add_seq against a plain-arithmetic model.
module tb_sint_chunked_add_seq;

  localparam int CHUNK_W = 7;
  localparam int NCHUNKS = 4;
  localparam int W       = CHUNK_W * NCHUNKS;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CIN;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] SUM;
  logic         COUT;
  logic         OVF;

  int n_checks = 0;
  int n_fail   = 0;

  sint_chunked_add_seq #(.CHUNK_W(CHUNK_W), .NCHUNKS(NCHUNKS)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .CIN       (CIN),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SUM       (SUM),
    .COUT      (COUT),
    .OVF       (OVF)
  );

  always #5 CLK = ~CLK;

  // Reference: true signed sum with integer arithmetic, then wrap or clamp.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] u;
    longint sa, sb, ss, smax, smin;
    u    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ss   = sa + sb + longint'(cin);
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    ov   = (ss > smax) || (ss < smin);
    co   = u[W];
    s    = u[W-1:0];
`ifdef SINT_CHUNKED_ADD_SATURATE_EN
    if (ov) s = (ss > 0) ? W'(smax) : W'(smin);
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    A = a; B = b; CIN = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic retire();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_txn(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin);
    logic [W-1:0] es;
    logic eco, eov;
    int lat;
    model(a, b, cin, es, eco, eov);
    send(a, b, cin);
    wait_result(lat);
    n_checks++;
    if (lat !== NCHUNKS) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, NCHUNKS);
    end
    n_checks++;
    if (SUM !== es) begin
      n_fail++;
      $display("FAIL %s SUM: got %h required %h", name, SUM, es);
    end
    n_checks++;
    if (COUT !== eco) begin
      n_fail++;
      $display("FAIL %s COUT: got %0b required %0b", name, COUT, eco);
    end
    n_checks++;
    if (OVF !== eov) begin
      n_fail++;
      $display("FAIL %s OVF: got %0b required %0b", name, OVF, eov);
    end
    $display("txn %s A=%h B=%h CIN=%0b -> SUM=%h COUT=%0b OVF=%0b lat=%0d",
             name, a, b, cin, SUM, COUT, OVF, lat);
    retire();
  endtask

  task automatic test_reset();
    RESET = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; CIN = 1'b0;
    repeat (3) tick();
    RESET = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (SUM !== '0 || COUT !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: SUM=%h COUT=%0b OVF=%0b required 0/0/0", SUM, COUT, OVF);
    end
    $display("txn reset in_ready=%0b out_valid=%0b SUM=%h", in_ready, out_valid, SUM);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [6] = '{28'h0000001, 28'h000007F, 28'h7FFFFFF, 28'hFFFFFFF, 28'h8000000, 28'hFFFFFFF};
    logic [W-1:0] tb [6] = '{28'h0000002, 28'h0000001, 28'h0000001, 28'h0000001, 28'h8000000, 28'hFFFFFFF};
    logic         tc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) check_txn($sformatf("dir%0d", i), ta[i], tb[i], tc[i]);
  endtask

  task automatic test_random();
    logic [W-1:0] edges [4] = '{28'h7FFFFFF, 28'h8000000, 28'hFFFFFFF, 28'h0000000};
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
      check_txn($sformatf("rnd%0d", i), a, b, 1'($urandom));
    end
  endtask

  // in_valid held with junk operands during RUN must not disturb the running add.
  task automatic test_busy_ignore();
    logic [W-1:0] es;
    logic eco, eov;
    int lat;
    model(28'h1234567, 28'h0ABCDEF, 1'b1, es, eco, eov);
    send(28'h1234567, 28'h0ABCDEF, 1'b1);
    A = 28'hFFFFFFF; B = 28'h5555555; CIN = 1'b0; in_valid = 1'b1;
    wait_result(lat);
    n_checks++;
    if (SUM !== es || COUT !== eco || OVF !== eov || lat !== NCHUNKS) begin
      n_fail++;
      $display("FAIL busy_ignore: SUM=%h COUT=%0b OVF=%0b lat=%0d required %h/%0b/%0b/%0d",
               SUM, COUT, OVF, lat, es, eco, eov, NCHUNKS);
    end
    $display("txn busy_ignore SUM=%h lat=%0d", SUM, lat);
    retire();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] es, es2, hs;
    logic eco, eov, eco2, eov2, hc, ho;
    int lat;
    model(28'h0001234, 28'h0004321, 1'b0, es, eco, eov);
    model(28'h0100000, 28'hFF00000, 1'b1, es2, eco2, eov2);
    send(28'h0001234, 28'h0004321, 1'b0);
    wait_result(lat);
    hs = SUM; hc = COUT; ho = OVF;
    n_checks++;
    if (hs !== es) begin
      n_fail++;
      $display("FAIL bp_first_sum: got %h required %h", hs, es);
    end
    A = 28'h0100000; B = 28'hFF00000; CIN = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (SUM !== es || COUT !== eco || OVF !== eov || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold%0d: SUM=%h COUT=%0b OVF=%0b in_ready=%0b out_valid=%0b required %h/%0b/%0b/0/1",
                 i, SUM, COUT, OVF, in_ready, out_valid, es, eco, eov);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || SUM !== hs || COUT !== hc || OVF !== ho) begin
      n_fail++;
      $display("FAIL bp_retire: in_ready=%0b out_valid=%0b SUM=%h required 1/0/%h",
               in_ready, out_valid, SUM, hs);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: in_ready=%0b required 0", in_ready);
    end
    wait_result(lat);
    n_checks++;
    if (SUM !== es2 || COUT !== eco2 || OVF !== eov2 || lat !== NCHUNKS) begin
      n_fail++;
      $display("FAIL bp_second: SUM=%h COUT=%0b OVF=%0b lat=%0d required %h/%0b/%0b/%0d",
               SUM, COUT, OVF, lat, es2, eco2, eov2, NCHUNKS);
    end
    $display("txn back_to_back first=%h second=%h lat=%0d", hs, SUM, lat);
    retire();
  endtask

  task automatic test_reset_midrun();
    send(28'h7654321, 28'h0123456, 1'b1);
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || SUM !== '0 || COUT !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: in_ready=%0b out_valid=%0b SUM=%h COUT=%0b OVF=%0b required 1/0/0/0/0",
               in_ready, out_valid, SUM, COUT, OVF);
    end
    $display("txn midrun_reset in_ready=%0b SUM=%h", in_ready, SUM);
    check_txn("after_reset", 28'h0000005, 28'hFFFFFFD, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sint_chunked_add_seq.md
Name: sint_chunked_add_seq

Overview:
Multi-precision signed adder sequencer that sits in front of the 7-bit add-with-carry stage.
- Accepts wide signed operands over a valid/ready handshake.
- Adds them one CHUNK_W-bit slice per cycle, least-significant first, chaining each slice's carry into the next slice's carry-in.
- Presents the full-width sum, raw carry-out and signed-overflow flag over an output valid/ready handshake.
- Lets wide SInt additions reuse one narrow carry adder instead of a full-width one.

Parameters:
- CHUNK_W, 7: slice width in bits. Matches the narrow add-with-carry stage.
- NCHUNKS, 4: number of slices. Must be ≥2. Total width W = CHUNK_W*NCHUNKS (28 by default).

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- A  in  W  signed operand A (two's complement)
- B  in  W  signed operand B
- CIN  in  1  carry-in to slice 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- SUM  out  W  A+B+CIN modulo 2^W (or saturated, see optional feature)
- COUT  out  1  unsigned carry out of bit W-1
- OVF  out  1  signed overflow of A+B+CIN

Behaviour:
- Interface: single clock CLK; reset is synchronous and active-high on RESET.
- Reset: state=IDLE, idx=0, carry reg=0, SUM=0, COUT=0, OVF=0, out_valid=0, in_ready=1 from the first cycle after RESET.
- States: IDLE, RUN, DONE. Encoding is held in the shared package.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state only.
- IDLE: on in_valid&&in_ready:
  - capture A, B into operand shift registers;
  - carry reg <= CIN; idx <= 0; state <= RUN.
- RUN, each cycle:
  - slice sum {c, s} = a_slice + b_slice + carry reg, using CHUNK_W+1-bit unsigned arithmetic (zero-extended);
  - s shifts into the SUM register from the top; operands shift right by CHUNK_W;
  - carry reg <= c; idx++.
- RUN, when idx==NCHUNKS-1 (last slice):
  - COUT <= c;
  - OVF <= (a_msb==b_msb) && (s_msb!=a_msb), where a_msb and b_msb are the MSBs of the final slices;
  - state <= DONE.
- Latency: accept edge at cycle T; out_valid is high from cycle T+NCHUNKS+1. Fixed; independent of data.
- DONE: SUM, COUT, OVF held stable while out_valid && !out_ready. On out_ready: state <= IDLE; outputs keep their last values (not cleared).
- No overlap: one transaction in flight. in_valid is ignored outside IDLE and must not disturb the shift registers.
- Simultaneous out_ready and in_valid in DONE: the result is retired; new operands are not accepted until the IDLE cycle.
- Wrap-around: the sum is modulo 2^W. CIN=1 with A=B=-1 gives SUM=-1, COUT=1, OVF=0.
- RESET mid-RUN or in DONE: the transaction is dropped and all reset values apply next cycle.
- idx width: $clog2(NCHUNKS). No wrap of idx beyond NCHUNKS-1.

Optional Feature:
- Macro: SINT_CHUNKED_ADD_SATURATE_EN.
- Defined: on the last slice, if the signed overflow term is 1, SUM is written as the signed limit: 0x7FF..F when a_msb==0, 0x800..0 when a_msb==1. OVF and COUT still report raw values.
- Not defined: SUM is always the wrapped modulo result. No saturation logic is present.

Decomposition:
- Package sint_chunked_add_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - default CHUNK_W and NCHUNKS constants;
  - localparam helpers for W and idx width;
  - saturation limit constants derived from W.
- One sub-module, sint_chunk_adc:
  - combinational CHUNK_W-bit add with carry-in, producing CHUNK_W sum bits plus carry-out;
  - instantiated once and time-shared across slices.

Test Plan:
1. A=1, B=2, CIN=0 accepted at T -> out_valid rises at T+5; SUM=3, COUT=0, OVF=0.
2. A=0x000007F, B=0x0000001, CIN=0 -> carry ripples across the slice boundary; SUM=0x0000080, COUT=0, OVF=0.
3. A=0x7FFFFFF, B=0x0000001 -> SUM=0x8000000, OVF=1, COUT=0. With SINT_CHUNKED_ADD_SATURATE_EN: SUM=0x7FFFFFF, OVF=1.
4. A=0xFFFFFFF (-1), B=0x0000001, CIN=0 -> SUM=0, COUT=1, OVF=0. A=B=0x8000000 -> SUM=0, COUT=1, OVF=1 (saturated build: SUM=0x8000000).
5. Result in DONE, out_ready held low 3 cycles with in_valid=1 and new operands -> SUM/COUT/OVF stable, in_ready=0. out_ready=1 -> IDLE next cycle, new operands accepted the cycle after.
6. RESET asserted in the second RUN cycle -> next cycle state=IDLE, in_ready=1, out_valid=0, SUM=0. A following A=5, B=-3 (0xFFFFFFD) -> SUM=2, COUT=1, OVF=0.
